// File: rtl/line_window_buf_pkg.sv
// Shared defaults and sizing helpers for the line window buffer.
package line_buf_pkg;
  localparam int DATA_W_DEF   = 8;
  localparam int STAT_W_DEF   = 1;
  localparam int TAPS_DEF     = 5;
  localparam int ADDR_W_DEF   = 12;
  localparam int STAT_TAP_DEF = 2;
  localparam int TAPS_MAX     = 9;
  // The line counter saturates at TAPS-1, so size it for the largest supported TAPS.
  localparam int LCNT_W       = $clog2(TAPS_MAX);

  function automatic int tap_lsb(input int tap, input int width);
    return tap * width;
  endfunction
endpackage

// File: rtl/line_window_buf_sp_ram.sv
// Single-port line memory: read-before-write with a registered read, both gated by en_i.
module sp_ram
  import line_buf_pkg::*;
#(
  parameter int WIDTH  = DATA_W_DEF + STAT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o
);
  logic [WIDTH-1:0] mem_q [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      rdata_q        <= mem_q[addr_i];
      mem_q[addr_i]  <= wdata_i;
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/line_window_buf.sv
// Vertical pixel window: chained line memories plus per-tap alignment delays present one
// aligned column (tap 0 = newest line) on stb_o, one cycle after every accepted pixel.
module line_window_buf
  import line_buf_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int STAT_W   = STAT_W_DEF,
  parameter int TAPS     = TAPS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int STAT_TAP = STAT_TAP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   sol,
  input  logic [ADDR_W-1:0]      line_len,
  input  logic [DATA_W-1:0]      data_in,
  input  logic [STAT_W-1:0]      stat_in,
  output logic [TAPS*DATA_W-1:0] taps_o,
  output logic [STAT_W-1:0]      stat_o,
  output logic                   stb_o,
  output logic                   filled_o
);
  localparam int PW = DATA_W + STAT_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [LCNT_W-1:0] LINES_FULL = LCNT_W'(TAPS - 1);

  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       len_q, len_d;
  logic [ADDR_W-1:0]       wr_addr;
  logic [LCNT_W-1:0]       lines_q, lines_d;
  logic                    line_done;
  logic                    stb_q;
  logic                    ram_en;
  logic [PW-1:0]           in_q;
  logic [TAPS-1:0][PW-1:0] stage_w;
  logic [TAPS-1:0][PW-1:0] tap_w;
  logic [TAPS-1:0]         unused_stat;

  // A sol landing on address 0 is the start of a line the wrap already counted.
  always_comb begin
    addr_d    = addr_q;
    len_d     = len_q;
    lines_d   = lines_q;
    line_done = 1'b0;
    wr_addr   = sol ? '0 : addr_q;
    if (en) begin
      if (sol) begin
        addr_d    = ADDR_ONE;
        len_d     = line_len;
        line_done = (addr_q != '0);
      end else if (addr_q == len_q - ADDR_ONE) begin
        addr_d    = '0;
        len_d     = line_len;
        line_done = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_ONE;
      end
      if (line_done && (lines_q != LINES_FULL)) begin
        lines_d = lines_q + LCNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      len_q   <= line_len;
      lines_q <= '0;
      stb_q   <= 1'b0;
      in_q    <= '0;
    end else begin
      addr_q  <= addr_d;
      len_q   <= len_d;
      lines_q <= lines_d;
      stb_q   <= en;
      if (en) begin
        in_q <= {stat_in, data_in};
      end
    end
  end

  assign ram_en     = en & ~rst;
  assign stage_w[0] = in_q;

  // Each memory stage delays by L+1 accepted samples: L from the address revisit, 1 from the read register.
  for (genvar k = 1; k < TAPS; k++) begin : g_ram
    sp_ram #(
      .WIDTH  (PW),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk_i   (clk),
      .en_i    (ram_en),
      .addr_i  (wr_addr),
      .wdata_i (stage_w[k-1]),
      .rdata_o (stage_w[k])
    );
  end

  for (genvar j = 0; j < TAPS; j++) begin : g_tap
    if (j == TAPS - 1) begin : g_direct
      assign tap_w[j] = stage_w[j];
    end else begin : g_dly
      localparam int D = TAPS - 1 - j;
      logic [D-1:0][PW-1:0] dly_q;
      always_ff @(posedge clk) begin
        if (rst) begin
          dly_q <= '0;
        end else if (en) begin
          dly_q[0] <= stage_w[j];
          for (int k = 1; k < D; k++) begin
            dly_q[k] <= dly_q[k-1];
          end
        end
      end
      assign tap_w[j] = dly_q[D-1];
    end

    if (j == STAT_TAP) begin : g_stat_used
      assign unused_stat[j] = 1'b0;
    end else begin : g_stat_drop
      assign unused_stat[j] = ^tap_w[j][PW-1:DATA_W];
    end
  end

  // Taps deeper than the number of completed lines would expose stale memory.
  always_comb begin
    taps_o = '0;
    stat_o = '0;
    for (int j = 0; j < TAPS; j++) begin
      if (lines_q >= LCNT_W'(j)) begin
        taps_o[tap_lsb(j, DATA_W) +: DATA_W] = tap_w[j][DATA_W-1:0];
      end
    end
    if (lines_q >= LCNT_W'(STAT_TAP)) begin
      stat_o = tap_w[STAT_TAP][PW-1:DATA_W];
    end
  end

  assign stb_o    = stb_q;
  assign filled_o = (lines_q == LINES_FULL);
endmodule

// File: tb/tb_line_window_buf.sv
// Directed bench for line_window_buf with L=4: ramp streams, gapped enables, sol and mid-stream reset.
module tb_line_window_buf;
  localparam int DW = 8;
  localparam int SW = 1;
  localparam int TP = 5;
  localparam int AW = 12;

  typedef struct {
    int              seq;
    int              n;
    logic [4:0][7:0] taps;
    logic [4:0]      care;
    logic            filled;
  } chk_t;

  logic             clk = 1'b0;
  logic             rst, en, sol;
  logic [AW-1:0]    line_len;
  logic [DW-1:0]    data_in;
  logic [SW-1:0]    stat_in;
  logic [TP*DW-1:0] taps_o;
  logic [SW-1:0]    stat_o;
  logic             stb_o, filled_o;

  int   errors = 0;
  int   checks = 0;
  chk_t tbl[$];

  always #5 clk = ~clk;

  line_window_buf #(
    .DATA_W(DW), .STAT_W(SW), .TAPS(TP), .ADDR_W(AW), .STAT_TAP(2)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .sol(sol), .line_len(line_len),
    .data_in(data_in), .stat_in(stat_in), .taps_o(taps_o), .stat_o(stat_o),
    .stb_o(stb_o), .filled_o(filled_o)
  );

  function automatic chk_t mk(int seq, int n, int t0, int t1, int t2, int t3, int t4,
                              logic [4:0] care, logic f);
    chk_t c;
    c.seq = seq; c.n = n;
    c.taps[0] = 8'(t0); c.taps[1] = 8'(t1); c.taps[2] = 8'(t2);
    c.taps[3] = 8'(t3); c.taps[4] = 8'(t4);
    c.care = care; c.filled = f;
    return c;
  endfunction

  task automatic chk(input string name, input int n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @sample %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic s, input logic [7:0] d,
                     input logic st);
    rst = r; en = e; sol = s; data_in = d; stat_in = st;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic chk_idle(input string tag, input int n);
    chk({tag, " stb"}, n, int'(stb_o), 0);
    chk({tag, " filled"}, n, int'(filled_o), 0);
    chk({tag, " stat"}, n, int'(stat_o), 0);
    for (int j = 0; j < TP; j++)
      chk($sformatf("%s tap%0d", tag, j), n, int'(taps_o[j*DW +: DW]), 0);
  endtask

  task automatic look(input int seq, input int n, input string tag);
    foreach (tbl[i]) begin
      if (tbl[i].seq == seq && tbl[i].n == n) begin
        for (int j = 0; j < TP; j++)
          if (tbl[i].care[j])
            chk($sformatf("%s tap%0d", tag, j), n, int'(taps_o[j*DW +: DW]), int'(tbl[i].taps[j]));
        chk({tag, " filled"}, n, int'(filled_o), int'(tbl[i].filled));
      end
    end
  endtask

  // Ramp from reset; with gaps, every accepted sample is followed by an ignored cycle carrying junk and sol.
  task automatic run_ramp(input bit gaps, input string tag);
    do_reset();
    for (int n = 0; n <= 40; n++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(n), (n == 20));
      chk({tag, " stb"}, n, int'(stb_o), 1);
      look(0, n, tag);
      if (n >= 12 || n <= 6) chk({tag, " stat"}, n, int'(stat_o), int'(n == 32));
      if (gaps) begin
        cyc(1'b0, 1'b0, 1'b1, 8'hAA, 1'b1);
        chk({tag, " stb idle"}, n, int'(stb_o), 0);
        look(0, n, {tag, " frozen"});
        if (n >= 12 || n <= 6) chk({tag, " stat frozen"}, n, int'(stat_o), int'(n == 32));
      end
    end
  endtask

  initial begin
    // seq 0: continuous ramp, tap j = n-4-4j once valid; -1 entries are don't-care
    tbl.push_back(mk(0,  2,  0,  0,  0,  0,  0, 5'b11111, 1'b0));
    tbl.push_back(mk(0,  9,  5,  1, -1,  0,  0, 5'b11011, 1'b0));
    tbl.push_back(mk(0, 12,  8,  4,  0, -1,  0, 5'b10111, 1'b0));
    tbl.push_back(mk(0, 15, 11,  7,  3, -1, -1, 5'b00111, 1'b1));
    tbl.push_back(mk(0, 20, 16, 12,  8,  4,  0, 5'b11111, 1'b1));
    tbl.push_back(mk(0, 30, 26, 22, 18, 14, 10, 5'b11111, 1'b1));
    tbl.push_back(mk(0, 35, 31, 27, 23, 19, 15, 5'b11111, 1'b1));
    // seq 1: sol at samples 6 (addr 2) and 10 (addr 0); addresses 0123 01 0123 0123 0...
    tbl.push_back(mk(1,  6,  2, -1, -1, -1, -1, 5'b00001, 1'b0));
    tbl.push_back(mk(1, 10,  6,  4, -1, -1,  0, 5'b10011, 1'b0));
    tbl.push_back(mk(1, 11,  7,  1, -1, -1,  0, 5'b10011, 1'b0));
    tbl.push_back(mk(1, 12,  8,  2, -1, -1,  0, 5'b10011, 1'b0));
    tbl.push_back(mk(1, 13,  9,  5, -1, -1, -1, 5'b00011, 1'b1));
    tbl.push_back(mk(1, 14, 10,  6, -1, -1, -1, 5'b00011, 1'b1));
    // seq 2: stream before the mid-stream reset
    tbl.push_back(mk(2, 16, 12,  8,  4,  0, -1, 5'b01111, 1'b1));
    // seq 3: after reset, data = 100 + post-reset index
    tbl.push_back(mk(3,  0,   0,   0,   0,   0,   0, 5'b11111, 1'b0));
    tbl.push_back(mk(3,  2,   0,   0,   0,   0,   0, 5'b11111, 1'b0));
    tbl.push_back(mk(3,  9, 105, 101,  -1,   0,   0, 5'b11011, 1'b0));
    tbl.push_back(mk(3, 14, 110, 106, 102,  -1,   0, 5'b10111, 1'b0));
    tbl.push_back(mk(3, 15, 111, 107, 103,  -1,  -1, 5'b00111, 1'b1));
    tbl.push_back(mk(3, 20, 116, 112, 108, 104, 100, 5'b11111, 1'b1));

    line_len = AW'(4);
    do_reset();
    chk_idle("reset", 0);

    run_ramp(1'b0, "cont");
    run_ramp(1'b1, "gapped");

    do_reset();
    for (int n = 0; n <= 17; n++) begin
      cyc(1'b0, 1'b1, (n == 6 || n == 10), 8'(n), 1'b0);
      look(1, n, "sol");
    end

    do_reset();
    for (int n = 0; n <= 16; n++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(n), 1'b0);
      look(2, n, "pre-rst");
    end
    cyc(1'b1, 1'b1, 1'b0, 8'd17, 1'b1);
    chk_idle("mid-rst", 17);
    for (int p = 0; p <= 20; p++) begin
      cyc(1'b0, 1'b1, 1'b0, 8'(100 + p), 1'b0);
      look(3, p, "post-rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
